// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg: shared types and helpers for pipe_stage_reg. Rev 1.0
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    localparam int PIPE_MAX_STAGES = 4;

    typedef logic [31:0] perf_cnt_t;

    typedef enum logic [1:0] {
        STG_LOAD   = 2'd0,
        STG_HOLD   = 2'd1,
        STG_BUBBLE = 2'd2
    } stage_ctl_t;

    // Saturating add; increment covers at most PIPE_MAX_STAGES per edge.
    function automatic perf_cnt_t sat_add(input perf_cnt_t cnt, input logic [2:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {30'd0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_slice: one valid+payload register with flush/hold/bubble/load mux.
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_stage_slice
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  stage_ctl_t        ctl,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_next;
    logic [DATA_W-1:0] data_next;

    always_comb begin
        valid_next = in_valid;
        data_next  = in_data;
        if (flush) begin
            valid_next = 1'b0;
            data_next  = BUBBLE_VAL;
        end else begin
            case (ctl)
                STG_HOLD: begin
                    valid_next = valid;
                    data_next  = data;
                end
                STG_BUBBLE: begin
                    valid_next = 1'b0;
                    data_next  = BUBBLE_VAL;
                end
                default: begin
                    valid_next = in_valid;
                    data_next  = in_data;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else begin
            valid <= valid_next;
            data  <= data_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_reg: STAGES-deep pipeline register with stall back-propagation,
// flush and bubble insertion. PIPE_STAGE_REG_PERF_EN adds perf counters. Rev 1.0
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                STAGES     = 1,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              accept_o,
    input  logic [STAGES-1:0] stall_i,
    input  logic [STAGES-1:0] flush_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [STAGES-1:0] stage_valid_o
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    output perf_cnt_t         stall_cnt_o,
    output perf_cnt_t         bubble_cnt_o,
    output perf_cnt_t         flush_cnt_o
`endif
);

    if (STAGES < 1 || STAGES > PIPE_MAX_STAGES) begin : g_bad_stages
        $error("pipe_stage_reg: STAGES out of range");
    end

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] up_hold;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] in_valid;
    logic [DATA_W-1:0] data_q  [STAGES];
    logic [DATA_W-1:0] in_data [STAGES];
    stage_ctl_t        ctl     [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // A stall anywhere downstream freezes this stage too.
        assign hold[k] = |stall_i[STAGES-1:k];

        if (k == 0) begin : g_head
            assign up_hold[k]  = 1'b0;
            assign in_valid[k] = valid_i;
            assign in_data[k]  = data_i;
        end else begin : g_body
            assign up_hold[k]  = hold[k-1];
            assign in_valid[k] = valid_q[k-1];
            assign in_data[k]  = data_q[k-1];
        end

        assign ctl[k] = hold[k]    ? STG_HOLD   :
                        up_hold[k] ? STG_BUBBLE : STG_LOAD;

        pipe_stage_slice #(
            .DATA_W     (DATA_W),
            .RESET_VAL  (RESET_VAL),
            .BUBBLE_VAL (BUBBLE_VAL)
        ) u_slice (
            .CLK      (CLK),
            .nRST     (nRST),
            .flush    (flush_i[k]),
            .ctl      (ctl[k]),
            .in_valid (in_valid[k]),
            .in_data  (in_data[k]),
            .valid    (valid_q[k]),
            .data     (data_q[k])
        );
    end

    assign accept_o      = !hold[0];
    assign valid_o       = valid_q[STAGES-1];
    assign data_o        = data_q[STAGES-1];
    assign stage_valid_o = valid_q;

`ifdef PIPE_STAGE_REG_PERF_EN
    logic      last_valid_next;
    logic [2:0] kill_cnt;
    perf_cnt_t stall_cnt;
    perf_cnt_t bubble_cnt;
    perf_cnt_t flush_cnt;

    assign last_valid_next = !flush_i[STAGES-1] &&
                             (hold[STAGES-1] ? valid_q[STAGES-1]
                                             : (!up_hold[STAGES-1] && in_valid[STAGES-1]));

    always_comb begin
        kill_cnt = '0;
        for (int k = 0; k < STAGES; k++) begin
            kill_cnt = kill_cnt + {2'b00, (flush_i[k] & valid_q[k])};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            stall_cnt  <= sat_add(stall_cnt,  {2'b00, hold[0]});
            bubble_cnt <= sat_add(bubble_cnt, {2'b00, !last_valid_next});
            flush_cnt  <= sat_add(flush_cnt,  kill_cnt);
        end
    end

    assign stall_cnt_o  = stall_cnt;
    assign bubble_cnt_o = bubble_cnt;
    assign flush_cnt_o  = flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg: randomized + directed bench against a reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int             DW    = 32;
    localparam int             ST    = 3;
    localparam logic [DW-1:0]  RST_V = 32'h5EED_0001;
    localparam logic [DW-1:0]  BUB_V = 32'hB0BB_1E00;
    localparam longint         CMAX  = 64'h0000_0000_FFFF_FFFF;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          accept_o;
    logic [ST-1:0] stall_i;
    logic [ST-1:0] flush_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic [ST-1:0] stage_valid_o;
`ifdef PIPE_STAGE_REG_PERF_EN
    perf_cnt_t     stall_cnt_o;
    perf_cnt_t     bubble_cnt_o;
    perf_cnt_t     flush_cnt_o;
`endif

    pipe_stage_reg #(
        .DATA_W     (DW),
        .STAGES     (ST),
        .RESET_VAL  (RST_V),
        .BUBBLE_VAL (BUB_V)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .valid_i       (valid_i),
        .data_i        (data_i),
        .accept_o      (accept_o),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .valid_o       (valid_o),
        .data_o        (data_o),
        .stage_valid_o (stage_valid_o)
`ifdef PIPE_STAGE_REG_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: one valid flag and payload per stage.
    bit            m_v [ST];
    logic [DW-1:0] m_d [ST];
    longint        m_stall, m_bubble, m_flush;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit held(input int k);
        for (int j = k; j < ST; j++) if (stall_i[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ST; k++) begin
            m_v[k] = 1'b0;
            m_d[k] = RST_V;
        end
        m_stall = 0; m_bubble = 0; m_flush = 0;
    endtask

    task automatic model_edge();
        bit            nv [ST];
        logic [DW-1:0] nd [ST];
        int            killed = 0;
        for (int k = 0; k < ST; k++) begin
            if (flush_i[k]) begin
                nv[k] = 1'b0; nd[k] = BUB_V;
                if (m_v[k]) killed++;
            end else if (held(k)) begin
                nv[k] = m_v[k]; nd[k] = m_d[k];
            end else if (k > 0 && held(k-1)) begin
                nv[k] = 1'b0; nd[k] = BUB_V;
            end else if (k == 0) begin
                nv[k] = valid_i; nd[k] = data_i;
            end else begin
                nv[k] = m_v[k-1]; nd[k] = m_d[k-1];
            end
        end
        if (held(0))    m_stall  = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
        if (!nv[ST-1])  m_bubble = (m_bubble + 1 > CMAX) ? CMAX : m_bubble + 1;
        m_flush = (m_flush + killed > CMAX) ? CMAX : m_flush + killed;
        for (int k = 0; k < ST; k++) begin
            m_v[k] = nv[k];
            m_d[k] = nd[k];
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [ST-1:0] sv;
        for (int k = 0; k < ST; k++) sv[k] = m_v[k];
        check_eq({tag, ".valid_o"},       {63'd0, valid_o},      {63'd0, m_v[ST-1]});
        check_eq({tag, ".data_o"},        {32'd0, data_o},       {32'd0, m_d[ST-1]});
        check_eq({tag, ".stage_valid_o"}, {61'd0, stage_valid_o}, {61'd0, sv});
`ifdef PIPE_STAGE_REG_PERF_EN
        check_eq({tag, ".stall_cnt"},  {32'd0, stall_cnt_o},  m_stall);
        check_eq({tag, ".bubble_cnt"}, {32'd0, bubble_cnt_o}, m_bubble);
        check_eq({tag, ".flush_cnt"},  {32'd0, flush_cnt_o},  m_flush);
`endif
    endtask

    // Called at a falling edge; drives inputs, checks, ends at next falling edge.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic [ST-1:0] st, input logic [ST-1:0] fl);
        valid_i = v; data_i = d; stall_i = st; flush_i = fl;
        #1;
        check_eq({tag, ".accept_o"}, {63'd0, accept_o}, {63'd0, !held(0)});
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs(tag);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0; valid_i = 1'b1; data_i = 32'hDEAD_BEEF;
        stall_i = '0; flush_i = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_outputs("reset");
        check_eq("reset.data_o_val", {32'd0, data_o}, {32'd0, RST_V});
        nRST = 1'b1;

        for (int i = 0; i < 3; i++) cycle("post_reset", 1'b1, 32'hDEAD_BEEF, '0, '0);
        check_eq("post_reset.deadbeef", {32'd0, data_o}, 64'hDEAD_BEEF);
        check_eq("post_reset.valid", {63'd0, valid_o}, 64'd1);

        for (int i = 1; i <= 6; i++) begin
            cycle("stream", (i <= 4), DW'(i), '0, '0);
            if (i >= 3) begin
                check_eq("stream.data_seq", {32'd0, data_o}, 64'(i - 2));
                check_eq("stream.valid_seq", {63'd0, valid_o}, 64'd1);
            end
        end

        // Load-use style: stall stage 0 only, stage 1 must receive a bubble.
        cycle("luse", 1'b1, 32'hA, '0, '0);
        cycle("luse", 1'b1, 32'hB, '0, '0);
        cycle("luse", 1'b1, 32'hC, 3'b001, '0);
        check_eq("luse.bubble_s1", {61'd0, stage_valid_o}, {61'd0, 3'b101});
        for (int i = 0; i < 3; i++) cycle("luse", 1'b1, 32'hC, '0, '0);

        cycle("dstall", 1'b1, 32'h11, 3'b100, '0);
        cycle("dstall", 1'b1, 32'h22, 3'b100, '0);
        cycle("dstall", 1'b1, 32'h33, '0, '0);

        cycle("flush", 1'b1, 32'h44, '0, '0);
        cycle("flush", 1'b1, 32'h55, 3'b011, 3'b011);
        check_eq("flush.bubble_data", {32'd0, dut.data_q[1]}, {32'd0, BUB_V});
        cycle("flush", 1'b1, 32'h66, 3'b100, 3'b100);

        // Asynchronous reset asserted mid-stall, away from any clock edge.
        cycle("prearst", 1'b1, 32'h77, 3'b010, '0);
        stall_i = 3'b010; flush_i = 3'b001;
        #2 nRST = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        @(negedge CLK);
        nRST = 1'b1;
        cycle("post_arst", 1'b1, 32'h88, '0, '0);

        for (int i = 0; i < 400; i++) begin
            logic [ST-1:0] st, fl;
            st = ($urandom_range(0, 3) == 0) ? ST'($urandom_range(0, 7)) : '0;
            fl = ($urandom_range(0, 5) == 0) ? ST'($urandom_range(0, 7)) : '0;
            cycle("rand", 1'($urandom_range(0, 1)), $urandom, st, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised multi-stage pipeline register that replaces the hand-written per-boundary latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Carries an opaque payload of DATA_W bits plus a valid bit through STAGES register slices.
- Supports per-stage stall with upstream back-propagation, per-stage flush, and automatic bubble insertion.
- The hazard unit drives stall/flush; the datapath packs and unpacks the payload.

Parameters:
- DATA_W, 32, payload width in bits (1..512).
- STAGES, 1, number of register slices in series (1..4).
- RESET_VAL, '0, payload value of every stage at reset.
- BUBBLE_VAL, '0, payload value loaded into a stage when it becomes a bubble (encodes regWEN=0, dMemWEN=0, halt=0).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- valid_i  input  1  upstream payload valid.
- data_i  input  DATA_W  upstream payload.
- accept_o  output  1  input captured at this edge; equals !hold[0].
- stall_i  input  STAGES  per-stage stall request; bit k holds stage k.
- flush_i  input  STAGES  per-stage flush request; bit k kills stage k.
- valid_o  output  1  valid of stage STAGES-1.
- data_o  output  DATA_W  payload of stage STAGES-1.
- stage_valid_o  output  STAGES  valid bit of every stage, for hazard/forwarding logic.

Behaviour:
- Stage 0 is nearest the input; stage STAGES-1 drives data_o/valid_o. All outputs are registered (no combinational path from *_i to data_o/valid_o); accept_o is combinational from stall_i.
- Reset (nRST=0, asynchronous): every stage valid=0, payload=RESET_VAL; valid_o=0, data_o=RESET_VAL, stage_valid_o=0. Reset mid-stall or mid-flush discards all contents; the first edge after deassertion behaves normally.
- hold[k] = OR(stall_i[STAGES-1:k]). A stall at a downstream stage freezes all upstream stages.
- Per stage k, on each rising edge, first match wins:
  1. flush_i[k]=1: valid=0, payload=BUBBLE_VAL, regardless of hold.
  2. hold[k]=1: keep current valid and payload.
  3. k>0 and hold[k-1]=1: bubble (valid=0, payload=BUBBLE_VAL). This is the stall-boundary bubble insertion.
  4. Otherwise: load from stage k-1, or from valid_i/data_i for k=0.
- Latency: 1 cycle per stage (STAGES cycles from data_i to data_o) when no stall.
- valid_i=0 with accept: payload is still loaded as presented; valid=0 marks it a bubble. The block does not substitute BUBBLE_VAL here.
- Simultaneous flush_i[k] and stall_i[k]: the flush wins; the stage becomes a bubble and upstream stages still hold.
- When data_i is presented while accept_o=0, the input is dropped. Upstream must re-present it; the PC latch stalls on the same signal.

Optional Feature:
- Macro: PIPE_STAGE_REG_PERF_EN.
- Defined: adds outputs stall_cnt_o, bubble_cnt_o and flush_cnt_o (32 bits each, saturating, reset 0).
  - stall_cnt_o increments on each edge with hold[0]=1.
  - bubble_cnt_o increments on each edge where the final stage's next valid=0.
  - flush_cnt_o adds the number of stages with flush_i[k]=1 and current valid=1 (valid entries killed).
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package pipe_stage_reg_pkg holds:
  - PIPE_MAX_STAGES=4;
  - typedef perf_cnt_t (logic [31:0]);
  - typedef stage_ctl_t enum {STG_LOAD, STG_HOLD, STG_BUBBLE} for stage next-state selection.
- Sub-module pipe_stage_slice (one valid+payload register with the priority mux) is instantiated STAGES times via generate. The top computes hold[] and the counters.

Test Plan:
- Reset: STAGES=3, hold nRST low with data_i=32'hDEADBEEF, valid_i=1 → valid_o=0, data_o=0, stage_valid_o=3'b000; deassert → data_o=32'hDEADBEEF, valid_o=1 three edges later.
- Streaming: STAGES=3, inputs 1,2,3,4 on consecutive cycles, no stall → data_o=1,2,3,4 on cycles 3..6, valid_o=1 throughout.
- Load-use stall: STAGES=2, payloads A,B,C, stall_i=2'b01 for one cycle while B is in stage 0 → accept_o=0 that cycle, stage 1 gets a bubble (valid_o=0, data_o=BUBBLE_VAL), then B and C follow; C is not lost.
- Downstream stall: STAGES=3, stall_i=3'b100 for 2 cycles → stage_valid_o and all payloads frozen; accept_o=0 for both cycles.
- Branch flush: STAGES=2, flush_i=2'b11 with stall_i=2'b11 on the same edge → both stages become valid=0/BUBBLE_VAL; with PIPE_STAGE_REG_PERF_EN, flush_cnt_o increases by 2 only if both stages were valid.
- Counter saturation (with PIPE_STAGE_REG_PERF_EN): force stall_cnt_o to 32'hFFFFFFFE, stall for 3 cycles → stall_cnt_o stays at 32'hFFFFFFFF.
